tt_fifo_rr_scheduler: RTL and testbench
=======================================

// Module: tt_fifo_rr_scheduler
// PURPOSE
//  Shares the 4-bit FIFO between NUM_REQ producers and sequences its read side toward one consumer.
//  Write side: round-robin arbiter; one grant per cycle drives FIFO write enable and data.
//  Read side: 3-state FSM issues FIFO reads and holds each word in a valid/ready output register.
//  Sits between the producer ports and the FIFO core in the TT user design.
// PARAMETERS
//  NUM_REQ  4  number of producers, 2..8
//  DATA_W   4  FIFO word width
// PORTS
//  clk           in   1                 single clock, rising edge
//  rst_n         in   1                 asynchronous reset, active-low
//  ena           in   1                 TT enable; low = no new grants and no new reads
//  req           in   NUM_REQ           producer i holds a word pending; keeps req and data stable until gnt[i]
//  req_data      in   NUM_REQ*DATA_W    producer i word at bits [i*DATA_W +: DATA_W]
//  gnt           out  NUM_REQ           one-hot; word i is written to the FIFO this cycle
//  fifo_full     in   1                 FIFO full flag
//  fifo_empty    in   1                 FIFO empty flag
//  fifo_wr_en    out  1                 FIFO write strobe, equals |gnt
//  fifo_wr_data  out  DATA_W            word of the granted producer; 0 when there is no grant
//  fifo_rd_en    out  1                 FIFO read strobe; data is valid on fifo_rd_data one cycle later
//  fifo_rd_data  in   DATA_W            FIFO registered read data
//  out_valid     out  1                 out_data holds an unconsumed word
//  out_data      out  DATA_W            held output word
//  out_ready     in   1                 consumer accepts when out_valid && out_ready
// BEHAVIOUR
//  Reset (rst_n low, asynchronous):
//   - ptr = 0, FSM = IDLE, out_valid = 0, out_data = 0
//   - gnt, fifo_wr_en, fifo_rd_en = 0 while rst_n is low
//   - a read in flight is discarded
//  Write arbiter (combinational from req, ptr, fifo_full, ena):
//   - Search req from index ptr upward with wrap; first set bit wins.
//   - gnt = 0 if fifo_full, !ena or req == 0.
//   - On a grant to k: ptr <= (k+1) mod NUM_REQ at the clock edge. Otherwise ptr holds.
//   - A pending req is never dropped; under full it waits, and the ptr order is preserved.
//   - Latency from req to gnt is 0 cycles if the FIFO is not full and req wins.
//   - No requester waits more than NUM_REQ-1 grants.
//  Read FSM:
//   - IDLE: fifo_rd_en = ena && !fifo_empty.
//       -> RD if fifo_rd_en.
//   - RD: out_data <= fifo_rd_data, out_valid <= 1.
//       -> HOLD.
//   - HOLD: on out_valid && out_ready:
//       - if ena && !fifo_empty: fifo_rd_en = 1, out_valid <= 0 -> RD (back-to-back, 1 word / 2 cycles)
//       - else: out_valid <= 0 -> IDLE
//     Without out_ready, stay in HOLD; out_data is stable.
//   - fifo_rd_en is never asserted in RD.
//  Boundary conditions:
//   - ena low mid-RD: the read completes into HOLD; no new read is issued.
//   - A write grant and fifo_rd_en in the same cycle are allowed and independent.
//   - fifo_empty in IDLE: stay in IDLE, fifo_rd_en = 0.
// CONFIGURATION
//  ARB_STATS_EN defined:
//   - Adds output port stall_cnt [7:0]: +1 on each cycle with (|req) && fifo_full && ena.
//   - Saturates at 255. Cleared to 0 by reset.
//  ARB_STATS_EN undefined: the port and counter do not exist; all other behaviour is identical.
// TESTING
//  1. Reset: rst_n=0 with req=4'b1111 -> gnt=0, out_valid=0, out_data=0; after release ptr=0, first gnt=4'b0001.
//  2. Round-robin: req=4'b1111 held, FIFO not full -> gnt sequence 0001,0010,0100,1000,0001;
//     fifo_wr_data follows req_data lanes.
//  3. Full stall: fifo_full=1, req=4'b0101 for 5 cycles -> gnt=0, stall_cnt=5 (ARB_STATS_EN);
//     after full drops -> gnt=0001, then 0100.
//  4. Read path: FIFO holds 4'hA, 4'hC, out_ready=1 ->
//     rd_en@t0, out_valid=1 out_data=A @t2, rd_en@t2, out_data=C @t4, then IDLE.
//  5. Backpressure: out_ready=0 for 6 cycles with word 4'h5 held ->
//     out_data=5 stable, fifo_rd_en=0; out_ready=1 -> out_valid drops next cycle.
//  6. Async reset asserted in RD -> out_valid=0 immediately, FSM=IDLE, no extra fifo_rd_en after release.

Source files
------------

// File: rtl/tt_fifo_rr_scheduler.sv
// tt_fifo_rr_scheduler
//   Shares one FIFO between NUM_REQ producers and sequences its read side
//   toward a single valid/ready consumer.
//   Write side: round-robin arbiter, at most one grant per cycle, driving
//   fifo_wr_en / fifo_wr_data directly (combinational from req, ptr, full, ena).
//   Read side: IDLE/RD/HOLD FSM; issues fifo_rd_en, captures the registered
//   FIFO read data one cycle later and holds it in out_valid/out_data.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   ena                 low = no new grants, no new reads
//   req, req_data       producer requests; word i at [i*DATA_W +: DATA_W]
//   gnt                 one-hot grant (word written this cycle)
//   fifo_full/empty     FIFO status flags
//   fifo_wr_en/wr_data  FIFO write strobe (= |gnt) and granted word (0 if none)
//   fifo_rd_en          FIFO read strobe, data on fifo_rd_data next cycle
//   fifo_rd_data        FIFO registered read data
//   out_valid/out_data  held output word
//   out_ready           consumer accept
//   stall_cnt [7:0]     only with ARB_STATS_EN: saturating count of cycles
//                       where a request is blocked by fifo_full while ena

module tt_fifo_rr_scheduler_lane #(
  parameter int DATA_W = 4
) (
  input  logic              gnt,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] data_q
);
  // Granted lane passes its word; others contribute zero to the OR-merge.
  assign data_q = gnt ? data : '0;
endmodule

module tt_fifo_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic                      fifo_full,
  input  logic                      fifo_empty,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic                      fifo_rd_en,
  input  logic [DATA_W-1:0]         fifo_rd_data,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready
`ifdef ARB_STATS_EN
  ,
  output logic [7:0]                stall_cnt
`endif
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // ---------------- write arbiter ----------------
  logic [PW-1:0]                    ptr, ptr_nx;
  logic [NUM_REQ-1:0]               mask, req_hi, pick_hi, pick_lo;
  logic                             arb_en;
  logic [NUM_REQ-1:0][DATA_W-1:0]   data_v;
  logic [NUM_REQ-1:0][DATA_W-1:0]   lane_q;

  assign data_v = req_data;
  assign arb_en = rst_n && ena && !fifo_full;

  // Two-pass priority: lowest set bit at or above ptr, else lowest overall
  // (the wrap). x & -x isolates the lowest set bit.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) mask[i] = (i >= int'(ptr));
    req_hi  = req & mask;
    pick_hi = req_hi & (~req_hi + NUM_REQ'(1));
    pick_lo = req & (~req + NUM_REQ'(1));
    gnt     = '0;
    if (arb_en) gnt = (|req_hi) ? pick_hi : pick_lo;
  end

  always_comb begin
    ptr_nx = ptr;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) ptr_nx = (i == NUM_REQ-1) ? '0 : PW'(i+1);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_nx;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    tt_fifo_rr_scheduler_lane #(.DATA_W(DATA_W)) u_lane (
      .gnt    (gnt[g]),
      .data   (data_v[g]),
      .data_q (lane_q[g])
    );
  end

  always_comb begin
    fifo_wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) fifo_wr_data = fifo_wr_data | lane_q[i];
  end

  assign fifo_wr_en = |gnt;

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      stall_cnt <= '0;
    else if ((|req) && fifo_full && ena && (stall_cnt != 8'hFF))
      stall_cnt <= stall_cnt + 8'd1;
`endif

  // ---------------- read FSM ----------------
  typedef enum logic [1:0] {IDLE, RD, HOLD} rd_state_t;

  rd_state_t         state, state_nx;
  logic              ov_nx;
  logic [DATA_W-1:0] od_nx;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nx;
      out_valid <= ov_nx;
      out_data  <= od_nx;
    end

  // RD is the cycle the FIFO presents the word requested last cycle; it
  // never issues a read, so ena dropping here just lets the word land.
  always_comb begin
    state_nx   = state;
    fifo_rd_en = 1'b0;
    ov_nx      = out_valid;
    od_nx      = out_data;
    if (rst_n) begin
      case (state)
        IDLE:
          if (ena && !fifo_empty) begin
            fifo_rd_en = 1'b1;
            state_nx   = RD;
          end
        RD: begin
          od_nx    = fifo_rd_data;
          ov_nx    = 1'b1;
          state_nx = HOLD;
        end
        HOLD:
          if (out_valid && out_ready) begin
            ov_nx = 1'b0;
            if (ena && !fifo_empty) begin
              fifo_rd_en = 1'b1;
              state_nx   = RD;
            end else begin
              state_nx = IDLE;
            end
          end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_fifo_rr_scheduler.sv
module tb_tt_fifo_rr_scheduler;
  logic        clk = 1'b0;
  logic        rst_n, ena;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic [3:0]  gnt;
  logic        fifo_full, fifo_empty, fifo_wr_en, fifo_rd_en;
  logic [3:0]  fifo_wr_data, out_data;
  logic [3:0]  fifo_rd_data = 4'h0;
  logic        out_valid, out_ready;
`ifdef ARB_STATS_EN
  logic [7:0]  stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tt_fifo_rr_scheduler #(.NUM_REQ(4), .DATA_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready)
`ifdef ARB_STATS_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  // Read-side FIFO stand-in: registered read data one cycle after rd_en.
  logic [3:0] mem [0:15];
  int wp = 0;
  int rp = 0;
  assign fifo_empty = (wp == rp);
  always @(posedge clk)
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[rp[3:0]];
      rp           <= rp + 1;
    end

  task automatic push(input logic [3:0] v);
    mem[wp[3:0]] = v;
    wp = wp + 1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    ena       = 1'b1;
    req       = 4'b1111;
    req_data  = {4'h4, 4'h3, 4'h2, 4'h1};
    fifo_full = 1'b0;
    out_ready = 1'b0;

    // 1. reset
    #3;
    chk("rst_gnt", gnt, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    #9 rst_n = 1'b1;
    #1;

    // 2. round-robin, two full laps (ends with ptr back at 0)
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rr_gnt%0d", k), gnt, 1 << (k % 4));
      chk($sformatf("rr_data%0d", k), fifo_wr_data, (k % 4) + 1);
      chk($sformatf("rr_wr_en%0d", k), fifo_wr_en, 1);
      tick();
    end

    // 3. full stall, order preserved
    req       = 4'b0101;
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("full_gnt%0d", k), gnt, 0);
      chk($sformatf("full_wr_data%0d", k), fifo_wr_data, 0);
      tick();
    end
`ifdef ARB_STATS_EN
    chk("stall_cnt5", stall_cnt, 5);
    ena = 1'b0;
    tick();
    chk("stall_cnt_ena_low", stall_cnt, 5);
`endif
    ena = 1'b0;
    fifo_full = 1'b0;
    #1 chk("ena_low_gnt", gnt, 0);
    ena = 1'b1;
    #1 chk("unfull_gnt0", gnt, 4'b0001);
    chk("unfull_data0", fifo_wr_data, 1);
    tick();
    chk("unfull_gnt2", gnt, 4'b0100);
    chk("unfull_data2", fifo_wr_data, 3);
    tick();

    // 4. read path A, C with out_ready=1; concurrent write grant at t0
    req       = 4'b0010;
    out_ready = 1'b1;
    push(4'hA);
    push(4'hC);
    #1;
    chk("t0_rd_en", fifo_rd_en, 1);
    chk("t0_gnt", gnt, 4'b0010);
    tick();
    req = 4'b0000;
    chk("t1_rd_en", fifo_rd_en, 0);
    chk("t1_valid", out_valid, 0);
    tick();
    chk("t2_valid", out_valid, 1);
    chk("t2_data", out_data, 4'hA);
    chk("t2_rd_en", fifo_rd_en, 1);
    tick();
    chk("t3_valid", out_valid, 0);
    chk("t3_rd_en", fifo_rd_en, 0);
    tick();
    chk("t4_valid", out_valid, 1);
    chk("t4_data", out_data, 4'hC);
    chk("t4_rd_en", fifo_rd_en, 0);
    tick();
    chk("t5_valid", out_valid, 0);
    chk("t5_rd_en", fifo_rd_en, 0);

    // 5. backpressure: 5 held while another word waits in the FIFO
    out_ready = 1'b0;
    push(4'h5);
    tick();
    push(4'h9);
    tick();
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("bp_valid%0d", k), out_valid, 1);
      chk($sformatf("bp_data%0d", k), out_data, 4'h5);
      chk($sformatf("bp_rd_en%0d", k), fifo_rd_en, 0);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("bp_release_rd_en", fifo_rd_en, 1);
    tick();
    chk("bp_drop_valid", out_valid, 0);
    tick();
    chk("bp_next_data", out_data, 4'h9);
    tick();
    chk("bp_idle_valid", out_valid, 0);

    // ena low mid-RD: word lands, no new read despite a non-empty FIFO
    push(4'h7);
    #1 chk("en_rd_en", fifo_rd_en, 1);
    tick();
    ena = 1'b0;
    push(4'h8);
    tick();
    chk("en_hold_valid", out_valid, 1);
    chk("en_hold_data", out_data, 4'h7);
    chk("en_hold_rd_en", fifo_rd_en, 0);
    tick();
    chk("en_idle_valid", out_valid, 0);
    chk("en_idle_rd_en", fifo_rd_en, 0);

    // 6. async reset while in RD
    ena = 1'b1;
    #1 chk("r6_rd_en", fifo_rd_en, 1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("r6_rst_valid", out_valid, 0);
    chk("r6_rst_data", out_data, 0);
    chk("r6_rst_rd_en", fifo_rd_en, 0);
    #5 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("r6_post_valid%0d", k), out_valid, 0);
      chk($sformatf("r6_post_rd_en%0d", k), fifo_rd_en, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
